// File: rtl/lfsr_seq_monitor_if.sv
// Sample-stream and status bundle for the 6-bit LFSR sequence monitor.
// The master drives samples; the slave (monitor) reports status.
interface lfsr_seq_monitor_if;
    logic       start;
    logic       in_valid;
    logic [5:0] state_in;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;
    logic [6:0] period;
    logic [6:0] sample_cnt;
    logic [5:0] last_bad;

    modport master (
        output start, in_valid, state_in,
        input  busy, done, err, err_code, period, sample_cnt, last_bad
    );

    modport slave (
        input  start, in_valid, state_in,
        output busy, done, err, err_code, period, sample_cnt, last_bad
    );
endinterface

// File: rtl/lfsr_seq_monitor.sv
// Checks a 6-bit LFSR state stream against its next-state map and reports
// the recurrence period of the seed, zero lock-up, step mismatch or timeout.
module lfsr_seq_monitor (
    input  logic                 clk,
    input  logic                 rst_n,
    lfsr_seq_monitor_if.slave    mon
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_RUN   = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    localparam logic [1:0] CODE_NONE     = 2'b00;
    localparam logic [1:0] CODE_MISMATCH = 2'b01;
    localparam logic [1:0] CODE_ZERO     = 2'b10;
    localparam logic [1:0] CODE_TIMEOUT  = 2'b11;
    localparam logic [6:0] CNT_LIMIT     = 7'd64;

    // s[0] does not feed the map, so two states can share a successor.
    function automatic logic [5:0] lfsr_nxt(input logic [5:0] s);
        lfsr_nxt = {s[4], s[3], s[5] ^ s[2], s[1], s[5] ^ s[1], s[5]};
    endfunction

    state_t     state_r,    state_s;
    logic [5:0] ref_r,      ref_s;
    logic [5:0] exp_r,      exp_s;
    logic [6:0] cnt_r,      cnt_s;
    logic [6:0] period_r,   period_s;
    logic [1:0] code_r,     code_s;
    logic [5:0] bad_r,      bad_s;
    logic       busy_r,     busy_s;
    logic       done_r,     done_s;
    logic       err_r,      err_s;
    logic [6:0] cnt_inc_s;

    // State and all status registers; outputs come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            ref_r    <= 6'd0;
            exp_r    <= 6'd0;
            cnt_r    <= 7'd0;
            period_r <= 7'd0;
            code_r   <= CODE_NONE;
            bad_r    <= 6'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            ref_r    <= ref_s;
            exp_r    <= exp_s;
            cnt_r    <= cnt_s;
            period_r <= period_s;
            code_r   <= code_s;
            bad_r    <= bad_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            err_r    <= err_s;
        end
    end

    // Next-state and next-status decode; start wins over any sample.
    always_comb begin
        state_s   = state_r;
        ref_s     = ref_r;
        exp_s     = exp_r;
        cnt_s     = cnt_r;
        period_s  = period_r;
        code_s    = code_r;
        bad_s     = bad_r;
        cnt_inc_s = cnt_r + 7'd1;

        if (mon.start) begin
            state_s  = ST_ARMED;
            cnt_s    = 7'd0;
            period_s = 7'd0;
            code_s   = CODE_NONE;
            bad_s    = 6'd0;
        end else begin
            case (state_r)
                ST_ARMED: begin
                    if (mon.in_valid) begin
                        ref_s = mon.state_in;
                        exp_s = lfsr_nxt(mon.state_in);
                        cnt_s = 7'd0;
                        if (mon.state_in == 6'd0) begin
                            state_s = ST_ERROR;
                            code_s  = CODE_ZERO;
                        end else begin
                            state_s = ST_RUN;
                        end
                    end else begin
                        state_s = ST_ARMED;
                    end
                end
                ST_RUN: begin
                    if (mon.in_valid) begin
                        cnt_s = cnt_inc_s;
                        if (mon.state_in != exp_r) begin
                            state_s = ST_ERROR;
                            code_s  = CODE_MISMATCH;
                            bad_s   = mon.state_in;
                        end else if (mon.state_in == 6'd0) begin
                            state_s = ST_ERROR;
                            code_s  = CODE_ZERO;
                        end else if (mon.state_in == ref_r) begin
                            state_s  = ST_DONE;
                            period_s = cnt_inc_s;
                        end else if (cnt_inc_s == CNT_LIMIT) begin
                            state_s = ST_ERROR;
                            code_s  = CODE_TIMEOUT;
                        end else begin
                            exp_s = lfsr_nxt(mon.state_in);
                        end
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_IDLE:  state_s = ST_IDLE;
                ST_DONE:  state_s = ST_DONE;
                ST_ERROR: state_s = ST_ERROR;
                default:  state_s = ST_IDLE;
            endcase
        end

        busy_s = (state_s == ST_ARMED) || (state_s == ST_RUN);
        done_s = (state_s == ST_DONE);
        err_s  = (state_s == ST_ERROR);
    end

    assign mon.busy       = busy_r;
    assign mon.done       = done_r;
    assign mon.err        = err_r;
    assign mon.err_code   = code_r;
    assign mon.period     = period_r;
    assign mon.sample_cnt = cnt_r;
    assign mon.last_bad   = bad_r;

endmodule

// File: tb/tb_lfsr_seq_monitor.sv
// Randomized self-checking bench for lfsr_seq_monitor against a
// list-walking reference model of the measurement rules.
module tb_lfsr_seq_monitor;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    lfsr_seq_monitor_if bus ();

    lfsr_seq_monitor dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mon   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [5:0]  seq_q[$];
    logic [24:0] obs;
    logic [24:0] want;

    // Successor as a shift with feedback taps applied when the top bit is set.
    function automatic logic [5:0] ref_step(input logic [5:0] s);
        logic [5:0] t;
        t    = {s[4:0], 1'b0};
        t[1] = s[1];
        if (s[5]) t = t ^ 6'b001011;
        return t;
    endfunction

    function automatic logic [24:0] pack_obs();
        return {bus.busy, bus.done, bus.err, bus.err_code, bus.period,
                bus.sample_cnt, bus.last_bad};
    endfunction

    // Walk seq_q as the measurement after a start and return the final status.
    function automatic logic [24:0] model_outcome();
        logic [5:0] seed;
        logic [5:0] prev;
        if (seq_q.size() == 0) return {1'b1, 1'b0, 1'b0, 2'b00, 7'd0, 7'd0, 6'd0};
        seed = seq_q[0];
        if (seed == 6'd0) return {1'b0, 1'b0, 1'b1, 2'b10, 7'd0, 7'd0, 6'd0};
        prev = seed;
        for (int i = 1; i < seq_q.size(); i++) begin
            if (seq_q[i] != ref_step(prev))
                return {1'b0, 1'b0, 1'b1, 2'b01, 7'd0, 7'(i), seq_q[i]};
            if (seq_q[i] == 6'd0)
                return {1'b0, 1'b0, 1'b1, 2'b10, 7'd0, 7'(i), 6'd0};
            if (seq_q[i] == seed)
                return {1'b0, 1'b1, 1'b0, 2'b00, 7'(i), 7'(i), 6'd0};
            if (i == 64)
                return {1'b0, 1'b0, 1'b1, 2'b11, 7'd0, 7'd64, 6'd0};
            prev = seq_q[i];
        end
        return {1'b1, 1'b0, 1'b0, 2'b00, 7'd0, 7'(seq_q.size() - 1), 6'd0};
    endfunction

    task automatic do_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic send(input logic [5:0] s, input int gap);
        for (int g = 0; g < gap; g++) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.state_in = s;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.state_in = 6'($urandom_range(0, 63));
    endtask

    task automatic drive_seq(input bit gaps);
        for (int i = 0; i < seq_q.size(); i++)
            send(seq_q[i], gaps ? int'($urandom_range(0, 2)) : 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        obs = pack_obs();
        checks++;
        if (obs !== 25'd0) begin
            failures++;
            $display("FAIL reset_values got=%h want=%h", obs, 25'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(6'b000010, 0);
        obs = pack_obs();
        checks++;
        if (obs !== 25'd0) begin
            failures++;
            $display("FAIL idle_ignores_sample got=%h want=%h", obs, 25'd0);
        end
    endtask

    task automatic test_clean_steps();
        do_start();
        seq_q = '{6'b000010, 6'b000110, 6'b001110, 6'b011110, 6'b111110, 6'b110101};
        drive_seq(1'b0);
        obs  = pack_obs();
        want = {1'b1, 1'b0, 1'b0, 2'b00, 7'd0, 7'd5, 6'd0};
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL clean_steps got=%h want=%h", obs, want);
        end
    endtask

    task automatic test_mismatch();
        do_start();
        seq_q = '{6'b000010, 6'b000111};
        drive_seq(1'b0);
        obs  = pack_obs();
        want = {1'b0, 1'b0, 1'b1, 2'b01, 7'd0, 7'd1, 6'b000111};
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL mismatch got=%h want=%h", obs, want);
        end
        send(6'b000110, 0);
        obs = pack_obs();
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL error_hold got=%h want=%h", obs, want);
        end
    endtask

    task automatic test_zero_lock();
        do_start();
        seq_q = '{6'b000001, 6'b000000};
        drive_seq(1'b0);
        obs  = pack_obs();
        want = {1'b0, 1'b0, 1'b1, 2'b10, 7'd0, 7'd1, 6'd0};
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL zero_lock_run got=%h want=%h", obs, want);
        end
        do_start();
        send(6'b000000, 0);
        obs  = pack_obs();
        want = {1'b0, 1'b0, 1'b1, 2'b10, 7'd0, 7'd0, 6'd0};
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL zero_lock_armed got=%h want=%h", obs, want);
        end
    endtask

    task automatic test_period_sweep();
        logic [5:0] s;
        for (int seed = 1; seed < 64; seed++) begin
            do_start();
            seq_q.delete();
            s = 6'(seed);
            seq_q.push_back(s);
            for (int k = 1; k <= 64; k++) begin
                s = ref_step(s);
                seq_q.push_back(s);
            end
            drive_seq(1'b1);
            obs  = pack_obs();
            want = model_outcome();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL period_seed_%0d got=%h want=%h", seed, obs, want);
            end
        end
    endtask

    task automatic test_random_streams();
        logic [5:0] s;
        int         len;
        for (int n = 0; n < 30; n++) begin
            do_start();
            seq_q.delete();
            s   = ($urandom_range(0, 9) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
            len = int'($urandom_range(1, 12));
            seq_q.push_back(s);
            for (int k = 1; k < len; k++) begin
                s = ref_step(s);
                seq_q.push_back(s);
            end
            if (len > 1 && $urandom_range(0, 1) == 1)
                seq_q[$urandom_range(1, len - 1)] = 6'($urandom_range(0, 63));
            drive_seq(1'b1);
            obs  = pack_obs();
            want = model_outcome();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL random_stream_%0d got=%h want=%h", n, obs, want);
            end
        end
    endtask

    task automatic test_start_override();
        do_start();
        send(6'b000010, 0);
        send(6'b000110, 0);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.in_valid = 1'b1;
        bus.state_in = 6'b001110;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        obs  = pack_obs();
        want = {1'b1, 1'b0, 1'b0, 2'b00, 7'd0, 7'd0, 6'd0};
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL start_override got=%h want=%h", obs, want);
        end
        // Only an armed monitor accepts 001110 again without a mismatch.
        send(6'b001110, 2);
        send(6'b011110, 1);
        obs  = pack_obs();
        want = {1'b1, 1'b0, 1'b0, 2'b00, 7'd0, 7'd1, 6'd0};
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL override_reseed got=%h want=%h", obs, want);
        end
    endtask

    task automatic test_async_reset();
        do_start();
        send(6'b000010, 0);
        send(6'b000110, 0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.sample_cnt !== 7'd0) begin
            failures++;
            $display("FAIL async_reset got busy=%b cnt=%0d want busy=0 cnt=0",
                     bus.busy, bus.sample_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send(6'b001110, 0);
        send(6'b011110, 0);
        obs = pack_obs();
        checks++;
        if (obs !== 25'd0) begin
            failures++;
            $display("FAIL reset_needs_start got=%h want=%h", obs, 25'd0);
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.state_in = 6'd0;
        rst_n        = 1'b1;
        test_reset();
        test_clean_steps();
        test_mismatch();
        test_zero_lock();
        test_period_sweep();
        test_random_streams();
        test_start_override();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule

// File: doc/lfsr_seq_monitor.md
LFSR_SEQ_MONITOR -- requirements
Module: lfsr_seq_monitor

Purpose: downstream checker for the 6-bit LFSR state stream. It verifies each step against the next-state function, then reports the recurrence period, zero lock-up, or a sequence error.

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  single-cycle pulse that arms a new measurement.
REQ-005 in_valid  input  1  state_in holds one LFSR state sample this cycle.
REQ-006 state_in  input  6  sampled LFSR register value.
REQ-007 busy  output  1  high in ARMED or RUN.
REQ-008 done  output  1  level; high in DONE.
REQ-009 err  output  1  level; high in ERROR.
REQ-010 err_code  output  2  00 none, 01 mismatch, 10 zero-lock, 11 timeout.
REQ-011 period  output  7  samples from seed to seed recurrence; valid while done=1.
REQ-012 sample_cnt  output  7  live count of RUN samples accepted.
REQ-013 last_bad  output  6  state_in captured on mismatch.

Function
REQ-014 Next-state function nxt(s) SHALL be {s[4], s[3], s[5]^s[2], s[1], s[5]^s[1], s[5]}.
- s[0] does not feed nxt().
- The map is therefore non-injective.
REQ-015 FSM states SHALL be IDLE, ARMED, RUN, DONE, ERROR, with all outputs registered.
REQ-016 start in any state SHALL move to ARMED next cycle.
- Clears period, sample_cnt, err_code, last_bad, done and err.
- start overrides a simultaneous in_valid; that sample is dropped.
REQ-017 ARMED with in_valid SHALL latch ref=state_in and exp=nxt(state_in).
- state_in==0: go to ERROR with code 10.
- Otherwise: go to RUN with sample_cnt=0.
REQ-018 RUN with in_valid SHALL increment sample_cnt, then check in this priority order:
- (a) state_in!=exp: ERROR, code 01, last_bad=state_in.
- (b) state_in==0: ERROR, code 10.
- (c) state_in==ref: DONE, period=new sample_cnt.
- (d) new sample_cnt==64: ERROR, code 11.
- (e) none of the above: exp=nxt(state_in), stay in RUN.
REQ-019 Cycles without in_valid SHALL hold all state; there is no inactivity timeout.
REQ-020 Status update latency SHALL be one cycle: outputs reflect a sample on the edge after it is presented.
REQ-021 DONE and ERROR SHALL hold all outputs until start or reset.
REQ-022 In IDLE, DONE and ERROR, in_valid SHALL be ignored.
REQ-023 sample_cnt SHALL never exceed 64, because REQ-018(d) stops counting there.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, independent of clk.
REQ-025 Reset values SHALL be: busy=0, done=0, err=0, err_code=00, period=0, sample_cnt=0, last_bad=0, ref=0, exp=0.
REQ-026 Reset mid-RUN SHALL discard the measurement; a new start is needed after release.

Verification
REQ-027 Clean steps: start; samples 000010, 000110, 001110, 011110, 111110, 110101.
- Required: busy=1, err=0, sample_cnt=5 after the last sample.
REQ-028 Mismatch: start; samples 000010, 000111.
- Required: err=1, err_code=01, last_bad=000111, sample_cnt=1, busy=0.
REQ-029 Zero-lock in RUN: start; samples 000001, 000000.
- Required: err_code=10.
- Zero-lock in ARMED: start; sample 000000. Required: err_code=10 with sample_cnt=0.
REQ-030 Period and timeout: for seeds 000001 to 111111, drive the nxt() trajectory from a bench model.
- Seed recurs at step k<=63: done=1, period=k.
- Seed absent after 64 samples: err_code=11, sample_cnt=64.
REQ-031 Control corners:
- start coincident with in_valid in RUN drops the sample (ARMED, sample_cnt=0).
- Gaps in in_valid do not change results.
- rst_n asserted mid-RUN between clock edges clears busy before the next edge.
